// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - rotating-priority two-port register writeback arbiter
module writeback_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu1_valid,
  input  logic [5:0]       alu1_rd,
  input  logic [WIDTH-1:0] alu1_data,
  output logic             alu1_ack,
  input  logic             alu2_valid,
  input  logic [5:0]       alu2_rd,
  input  logic [WIDTH-1:0] alu2_data,
  output logic             alu2_ack,
  input  logic             advint_valid,
  input  logic [5:0]       advint_rd,
  input  logic [WIDTH-1:0] advint_data,
  input  logic [5:0]       advint_rd2,
  input  logic [WIDTH-1:0] advint_data2,
  output logic             advint_ack,
  input  logic             memunit_valid,
  input  logic [5:0]       memunit_rd,
  input  logic [WIDTH-1:0] memunit_data,
  output logic             memunit_ack,
  input  logic             branch_valid,
  input  logic [5:0]       branch_rd,
  input  logic [WIDTH-1:0] branch_data,
  output logic             branch_ack,
  output logic             wr1_en,
  output logic [5:0]       wr1_rn,
  output logic [WIDTH-1:0] wr1_data,
  output logic             wr2_en,
  output logic [5:0]       wr2_rn,
  output logic [WIDTH-1:0] wr2_data,
  output logic [5:0]       reg1_finished,
  output logic [5:0]       reg2_finished
);

  // Source order: alu1=0, alu2=1, advint=2, memunit=3, branch=4
  logic [4:0]       vld;
  logic [5:0]       rd_a   [5];
  logic [WIDTH-1:0] data_a [5];
  logic [1:0]       need   [5];
  logic [4:0]       ack;

  logic             wr1_en_q, wr1_en_d, wr2_en_q, wr2_en_d;
  logic [5:0]       wr1_rn_q, wr1_rn_d, wr2_rn_q, wr2_rn_d;
  logic [WIDTH-1:0] wr1_data_q, wr1_data_d, wr2_data_q, wr2_data_d;
  logic [2:0]       ptr_q, ptr_d;

  assign vld = {branch_valid, memunit_valid, advint_valid, alu2_valid, alu1_valid};

  // Per-source primary destination and number of ports needed; advint may need two
  always_comb begin
    rd_a[0]   = alu1_rd;    data_a[0] = alu1_data;    need[0] = {1'b0, alu1_rd != 6'd0};
    rd_a[1]   = alu2_rd;    data_a[1] = alu2_data;    need[1] = {1'b0, alu2_rd != 6'd0};
    rd_a[3]   = memunit_rd; data_a[3] = memunit_data; need[3] = {1'b0, memunit_rd != 6'd0};
    rd_a[4]   = branch_rd;  data_a[4] = branch_data;  need[4] = {1'b0, branch_rd != 6'd0};
    rd_a[2]   = advint_rd;
    data_a[2] = advint_data;
    need[2]   = 2'd0;
    if (advint_rd != 6'd0) begin
      // rd == rd2 collapses to a single write of the primary result
      need[2] = (advint_rd2 != 6'd0 && advint_rd2 != advint_rd) ? 2'd2 : 2'd1;
    end else if (advint_rd2 != 6'd0) begin
      rd_a[2]   = advint_rd2;
      data_a[2] = advint_data2;
      need[2]   = 2'd1;
    end
  end

  // Rotating scan from ptr: grant sources that fit the remaining ports, fill port 1 first
  always_comb begin
    logic [1:0] free;
    logic [3:0] sum;
    logic [2:0] idx;
    ack        = 5'd0;
    wr1_en_d   = 1'b0;
    wr1_rn_d   = 6'd0;
    wr1_data_d = '0;
    wr2_en_d   = 1'b0;
    wr2_rn_d   = 6'd0;
    wr2_data_d = '0;
    ptr_d      = ptr_q;
    free       = 2'd2;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, ptr_q} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      idx = sum[2:0];
      if (vld[idx]) begin
        if (need[idx] == 2'd0) begin
          ack[idx] = 1'b1;
        end else if (need[idx] <= free) begin
          ack[idx] = 1'b1;
          if (free == 2'd2) begin
            wr1_en_d   = 1'b1;
            wr1_rn_d   = rd_a[idx];
            wr1_data_d = data_a[idx];
            if (need[idx] == 2'd2) begin
              wr2_en_d   = 1'b1;
              wr2_rn_d   = advint_rd2;
              wr2_data_d = advint_data2;
            end
          end else begin
            wr2_en_d   = 1'b1;
            wr2_rn_d   = rd_a[idx];
            wr2_data_d = data_a[idx];
          end
          free  = free - need[idx];
          ptr_d = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
      end
    end
  end

  // Write-port registers and scan pointer; reset discards any in-flight grant
  always_ff @(posedge clk) begin
    if (rst) begin
      wr1_en_q   <= 1'b0;
      wr1_rn_q   <= 6'd0;
      wr1_data_q <= '0;
      wr2_en_q   <= 1'b0;
      wr2_rn_q   <= 6'd0;
      wr2_data_q <= '0;
      ptr_q      <= 3'd0;
    end else begin
      wr1_en_q   <= wr1_en_d;
      wr1_rn_q   <= wr1_rn_d;
      wr1_data_q <= wr1_data_d;
      wr2_en_q   <= wr2_en_d;
      wr2_rn_q   <= wr2_rn_d;
      wr2_data_q <= wr2_data_d;
      ptr_q      <= ptr_d;
    end
  end

  assign alu1_ack    = ack[0] & ~rst;
  assign alu2_ack    = ack[1] & ~rst;
  assign advint_ack  = ack[2] & ~rst;
  assign memunit_ack = ack[3] & ~rst;
  assign branch_ack  = ack[4] & ~rst;

  assign wr1_en        = wr1_en_q;
  assign wr1_rn        = wr1_rn_q;
  assign wr1_data      = wr1_data_q;
  assign wr2_en        = wr2_en_q;
  assign wr2_rn        = wr2_rn_q;
  assign wr2_data      = wr2_data_q;
  assign reg1_finished = wr1_en_q ? wr1_rn_q : 6'd0;
  assign reg2_finished = wr2_en_q ? wr2_rn_q : 6'd0;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic rst;
  logic alu1_valid, alu2_valid, advint_valid, memunit_valid, branch_valid;
  logic [5:0] alu1_rd, alu2_rd, advint_rd, advint_rd2, memunit_rd, branch_rd;
  logic [WIDTH-1:0] alu1_data, alu2_data, advint_data, advint_data2, memunit_data, branch_data;
  logic alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack;
  logic wr1_en, wr2_en;
  logic [5:0] wr1_rn, wr2_rn, reg1_finished, reg2_finished;
  logic [WIDTH-1:0] wr1_data, wr2_data;

  int n_checks = 0;
  int n_fail = 0;

  writeback_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .alu1_valid(alu1_valid), .alu1_rd(alu1_rd), .alu1_data(alu1_data), .alu1_ack(alu1_ack),
    .alu2_valid(alu2_valid), .alu2_rd(alu2_rd), .alu2_data(alu2_data), .alu2_ack(alu2_ack),
    .advint_valid(advint_valid), .advint_rd(advint_rd), .advint_data(advint_data),
    .advint_rd2(advint_rd2), .advint_data2(advint_data2), .advint_ack(advint_ack),
    .memunit_valid(memunit_valid), .memunit_rd(memunit_rd), .memunit_data(memunit_data),
    .memunit_ack(memunit_ack),
    .branch_valid(branch_valid), .branch_rd(branch_rd), .branch_data(branch_data),
    .branch_ack(branch_ack),
    .wr1_en(wr1_en), .wr1_rn(wr1_rn), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_rn(wr2_rn), .wr2_data(wr2_data),
    .reg1_finished(reg1_finished), .reg2_finished(reg2_finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    alu1_valid = 0; alu1_rd = 0; alu1_data = 0;
    alu2_valid = 0; alu2_rd = 0; alu2_data = 0;
    advint_valid = 0; advint_rd = 0; advint_data = 0; advint_rd2 = 0; advint_data2 = 0;
    memunit_valid = 0; memunit_rd = 0; memunit_data = 0;
    branch_valid = 0; branch_rd = 0; branch_data = 0;
  endtask

  task automatic check_wr(input string tag, input logic e1, input logic [5:0] r1,
                          input logic [63:0] d1, input logic e2, input logic [5:0] r2,
                          input logic [63:0] d2);
    check({tag, ".wr1"}, {wr1_en, wr1_rn, reg1_finished}, {e1, r1, e1 ? r1 : 6'd0});
    check({tag, ".wr1_data"}, wr1_data, d1);
    check({tag, ".wr2"}, {wr2_en, wr2_rn, reg2_finished}, {e2, r2, e2 ? r2 : 6'd0});
    check({tag, ".wr2_data"}, wr2_data, d2);
  endtask

  function automatic logic [4:0] acks();
    return {branch_ack, memunit_ack, advint_ack, alu2_ack, alu1_ack};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    alu1_valid = 1; alu1_rd = 6'd1; alu1_data = 64'h1;
    settle();
    check("ack_in_reset", 64'(acks()), 64'h0);
    step(); step();
    check_wr("reset", 0, 0, 0, 0, 0, 0);
    clear_inputs();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_outputs", {wr1_en, wr2_en, wr1_rn, wr2_rn, reg1_finished, reg2_finished}, 64'h0);
    end

    // single alu1 write, ptr 0 -> 1
    alu1_valid = 1; alu1_rd = 6'd5; alu1_data = 64'h11;
    settle();
    check("single_ack", 64'(acks()), 64'b00001);
    step(); clear_inputs();
    check_wr("single", 1, 5, 64'h11, 0, 0, 0);

    // three need-1 sources from ptr 0
    do_reset();
    alu1_valid = 1; alu1_rd = 6'd3; alu1_data = 64'hA;
    alu2_valid = 1; alu2_rd = 6'd4; alu2_data = 64'hB;
    memunit_valid = 1; memunit_rd = 6'd9; memunit_data = 64'hC;
    settle();
    check("three_ack_n", 64'(acks()), 64'b00011);
    step();
    alu1_valid = 0; alu2_valid = 0;
    check_wr("three_n1", 1, 3, 64'hA, 1, 4, 64'hB);
    settle();
    check("three_ack_n1", 64'(acks()), 64'b01000);
    step(); clear_inputs();
    check_wr("three_n2", 1, 9, 64'hC, 0, 0, 0);
    step();
    check_wr("three_idle", 0, 0, 0, 0, 0, 0);

    // advint need 2 skipped behind alu1, then granted; branch waits
    do_reset();
    advint_valid = 1; advint_rd = 6'd7; advint_rd2 = 6'd8;
    advint_data = 64'h70; advint_data2 = 64'h80;
    alu1_valid = 1; alu1_rd = 6'd2; alu1_data = 64'h20;
    settle();
    check("adv_ack_n", 64'(acks()), 64'b00001);
    step();
    alu1_valid = 0;
    branch_valid = 1; branch_rd = 6'd10; branch_data = 64'hB0;
    check_wr("adv_n1", 1, 2, 64'h20, 0, 0, 0);
    settle();
    check("adv_ack_n1", 64'(acks()), 64'b00100);
    step();
    advint_valid = 0;
    check_wr("adv_n2", 1, 7, 64'h70, 1, 8, 64'h80);
    settle();
    check("branch_ack_n2", 64'(acks()), 64'b10000);
    step(); clear_inputs();
    check_wr("adv_n3", 1, 10, 64'hB0, 0, 0, 0);

    // need-0 sources: acked, no write, ptr stays 0
    branch_valid = 1; branch_rd = 6'd0; branch_data = 64'hFF;
    settle();
    check("branch_rd0_ack", 64'(acks()), 64'b10000);
    step(); clear_inputs();
    check_wr("branch_rd0", 0, 0, 0, 0, 0, 0);
    memunit_valid = 1; memunit_rd = 6'd0;
    settle();
    check("mem_rd0_ack", 64'(acks()), 64'b01000);
    step(); clear_inputs();
    alu1_valid = 1; alu1_rd = 6'd21; alu1_data = 64'h210;
    branch_valid = 1; branch_rd = 6'd20; branch_data = 64'h200;
    settle();
    check("ptr_kept_ack", 64'(acks()), 64'b10001);
    step(); clear_inputs();
    check_wr("ptr_kept", 1, 21, 64'h210, 1, 20, 64'h200);

    // advint rd == rd2: single write, port 2 left for memunit
    advint_valid = 1; advint_rd = 6'd12; advint_rd2 = 6'd12;
    advint_data = 64'h120; advint_data2 = 64'h999;
    memunit_valid = 1; memunit_rd = 6'd13; memunit_data = 64'h130;
    settle();
    check("same_rd_ack", 64'(acks()), 64'b01100);
    step(); clear_inputs();
    check_wr("same_rd", 1, 12, 64'h120, 1, 13, 64'h130);

    // advint with only rd2 uses rd2/data2
    advint_valid = 1; advint_rd = 6'd0; advint_rd2 = 6'd14;
    advint_data = 64'h555; advint_data2 = 64'h140;
    settle();
    check("rd2_only_ack", 64'(acks()), 64'b00100);
    step(); clear_inputs();
    check_wr("rd2_only", 1, 14, 64'h140, 0, 0, 0);

    // reset mid-operation: pending result survives and is re-arbitrated
    alu2_valid = 1; alu2_rd = 6'd30; alu2_data = 64'h300;
    rst = 1'b1;
    settle();
    check("mid_rst_ack", 64'(acks()), 64'h0);
    step();
    rst = 1'b0;
    check_wr("mid_rst", 0, 0, 0, 0, 0, 0);
    settle();
    check("after_rst_ack", 64'(acks()), 64'b00010);
    step(); clear_inputs();
    check_wr("after_rst", 1, 30, 64'h300, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
